// File: rtl/spi_master_multi_pkg.sv
// Shared types for the multi-select SPI master: FSM states and the latched bus mode.
package spi_master_multi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    BURST
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// Word-level request/response bus between a register/DMA front end and the SPI master.
interface spi_master_multi_if
  import spi_master_multi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
);
  localparam int CS_W = cs_width(NUM_CS);

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;

  // Front end that issues words
  modport master (
    output tx_valid, tx_data, tx_last, cs_sel, cpol, cpha, clk_div,
    input  tx_ready, rx_valid, rx_data, busy
  );

  // SPI engine that serves them
  modport slave (
    input  tx_valid, tx_data, tx_last, cs_sel, cpol, cpha, clk_div,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_multi_sclk_gen.sv
// Half-period timer and registered SCLK; strobes mark the cycle before each SCLK edge.
module spi_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             run,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             half_stb,
  output logic             lead_stb,
  output logic             trail_stb
);
  logic [DIV_W-1:0] cnt;

  assign half_stb  = en && (cnt == div);
  // SCLK at its idle level means the next toggle is a leading edge
  assign lead_stb  = half_stb && run && (sclk == cpol);
  assign trail_stb = half_stb && run && (sclk != cpol);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= cpol;
    end else begin
      cnt <= half_stb ? '0 : cnt + 1'b1;
      if (half_stb && run) sclk <= ~sclk;
    end
  end
endmodule

// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA and divider, NUM_CS selects and CS-held bursts.
module spi_master_multi
  import spi_master_multi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 4,
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_multi_if.slave bus,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);
  localparam int CS_W = cs_width(NUM_CS);
  localparam int EW   = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);

  spi_state_e        state;
  spi_mode_t         mode;
  logic [DIV_W-1:0]  div_l;
  logic              last_l;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [EW-1:0]     edge_cnt;
  logic              tx_ready_r;
  logic              rx_valid_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              busy_r;

  logic half_stb, lead_stb, trail_stb;
  logic gen_en, gen_run, idle_pol;
  logic accept, acc_cpha, final_edge, sample_stb, drive_stb;
  logic [DATA_W-1:0] rx_next;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Out-of-range selects decode to no line asserted
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] d;
    d = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) d[i] = 1'b0;
    end
    return d;
  endfunction

  assign gen_en   = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign gen_run  = (state == XFER);
  assign idle_pol = (state == IDLE) ? bus.cpol : mode.cpol;

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (gen_en),
    .run       (gen_run),
    .cpol      (idle_pol),
    .div       (div_l),
    .sclk      (spi_sclk),
    .half_stb  (half_stb),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  assign accept     = tx_ready_r && bus.tx_valid;
  assign acc_cpha   = (state == IDLE) ? bus.cpha : mode.cpha;
  assign final_edge = (edge_cnt == E_LAST);
  assign sample_stb = mode.cpha ? trail_stb : lead_stb;
  assign drive_stb  = mode.cpha ? lead_stb : (trail_stb && !final_edge);
  assign rx_next    = shift_in(rx_sh, spi_miso);

  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.busy     = busy_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= '0;
      div_l      <= '0;
      last_l     <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      edge_cnt   <= '0;
      tx_ready_r <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
      busy_r     <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= '1;
    end else begin
      rx_valid_r <= 1'b0;
      case (state)
        IDLE, BURST: begin
          if (accept) begin
            // Mode and select are taken only at the start of a burst
            if (state == IDLE) begin
              mode     <= '{cpol: bus.cpol, cpha: bus.cpha};
              spi_cs_n <= cs_decode(bus.cs_sel);
            end
            div_l    <= bus.clk_div;
            last_l   <= bus.tx_last;
            edge_cnt <= '0;
            if (!acc_cpha) begin
              spi_mosi <= out_bit(bus.tx_data);
              tx_sh    <= shift_out(bus.tx_data);
            end else begin
              tx_sh <= bus.tx_data;
            end
            state      <= SETUP;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            tx_ready_r <= 1'b1;
            busy_r     <= (state == BURST);
          end
        end
        SETUP: begin
          if (half_stb) state <= XFER;
        end
        XFER: begin
          if (sample_stb) rx_sh <= rx_next;
          if (drive_stb) begin
            spi_mosi <= out_bit(tx_sh);
            tx_sh    <= shift_out(tx_sh);
          end
          if (half_stb) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (final_edge) begin
              rx_data_r  <= sample_stb ? rx_next : rx_sh;
              rx_valid_r <= 1'b1;
              if (last_l) begin
                state <= HOLD;
              end else begin
                state      <= BURST;
                tx_ready_r <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (half_stb) begin
            state      <= IDLE;
            spi_cs_n   <= '1;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          spi_cs_n   <= '1;
          tx_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: 8-bit/4-CS and 16-bit/5-CS builds.
`timescale 1ns/1ps
module tb_spi_master_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_W(8),  .NUM_CS(4), .DIV_W(8)) b8 ();
  spi_master_multi_if #(.DATA_W(16), .NUM_CS(5), .DIV_W(8)) b16 ();

  logic       sclk8, mosi8, miso8;
  logic [3:0] cs8;
  logic       sclk16, mosi16, miso16;
  logic [4:0] cs16;

  logic       miso_sel = 1'b0;
  logic       dev_miso = 1'b0;
  logic [7:0] dev_word = 8'h00;
  int         dev_idx  = 0;

  assign miso8  = miso_sel ? dev_miso : mosi8;
  assign miso16 = mosi16;

  spi_master_multi #(.DATA_W(8), .NUM_CS(4), .DIV_W(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst(rst), .bus(b8),
    .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_miso(miso8), .spi_cs_n(cs8)
  );

  spi_master_multi #(.DATA_W(16), .NUM_CS(5), .DIV_W(8), .MSB_FIRST(1'b1)) u16 (
    .clk(clk), .rst(rst), .bus(b16),
    .spi_sclk(sclk16), .spi_mosi(mosi16), .spi_miso(miso16), .spi_cs_n(cs16)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Monitors: SCLK rising-edge timestamps, rx strobes, CS pattern while busy, MOSI edge discipline
  longint     rise_t8  [256];
  longint     rise_t16 [256];
  int         rise8 = 0, rise16 = 0;
  int         rxv8 = 0, rxv16 = 0;
  int         cs_bad8 = 0, cs_bad16 = 0;
  int         mosi_bad8 = 0;
  logic [3:0] exp_cs8  = 4'hF;
  logic [4:0] exp_cs16 = 5'h1F;
  logic [7:0] cap8 = 8'h00;
  logic       prev_sclk8 = 1'b0, prev_mosi8 = 1'b0, prev_cs0 = 1'b1;

  always @(posedge sclk8) begin
    rise_t8[rise8 & 255] = $time;
    rise8++;
    if (cs8[0] === 1'b0) cap8 = {cap8[6:0], mosi8};
  end

  always @(posedge sclk16) begin
    rise_t16[rise16 & 255] = $time;
    rise16++;
  end

  always @(negedge sclk8 or posedge cs8[0]) begin
    if (cs8[0] !== 1'b0) begin
      dev_idx = 0;
    end else if (dev_idx < 8) begin
      dev_miso = dev_word[7 - dev_idx];
      dev_idx++;
    end
  end

  always @(negedge clk) begin
    if (b8.rx_valid === 1'b1) rxv8++;
    if (b16.rx_valid === 1'b1) rxv16++;
    if (b8.busy === 1'b1 && cs8 !== exp_cs8) cs_bad8++;
    if (b16.busy === 1'b1 && cs16 !== exp_cs16) cs_bad16++;
    if (prev_cs0 === 1'b0 && mosi8 !== prev_mosi8 && !(prev_sclk8 === 1'b1 && sclk8 === 1'b0))
      mosi_bad8++;
    prev_sclk8 = sclk8;
    prev_mosi8 = mosi8;
    prev_cs0   = cs8[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic last, input logic [1:0] sel,
                       input logic pol, input logic pha, input logic [7:0] div);
    int t;
    b8.tx_data = d; b8.tx_last = last; b8.cs_sel = sel;
    b8.cpol = pol; b8.cpha = pha; b8.clk_div = div; b8.tx_valid = 1'b1;
    t = 0;
    while (b8.tx_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("send8_ready_wait", {31'd0, b8.tx_ready}, 32'd1);
    @(negedge clk);
    b8.tx_valid = 1'b0;
  endtask

  task automatic wait_rx8(output logic [7:0] d);
    int t;
    t = 0;
    while (b8.rx_valid !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("rx8_wait", {31'd0, b8.rx_valid}, 32'd1);
    d = b8.rx_data;
  endtask

  task automatic send16(input logic [15:0] d, input logic [2:0] sel, input logic [7:0] div);
    int t;
    b16.tx_data = d; b16.tx_last = 1'b1; b16.cs_sel = sel;
    b16.cpol = 1'b0; b16.cpha = 1'b0; b16.clk_div = div; b16.tx_valid = 1'b1;
    t = 0;
    while (b16.tx_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("send16_ready_wait", {31'd0, b16.tx_ready}, 32'd1);
    @(negedge clk);
    b16.tx_valid = 1'b0;
  endtask

  task automatic wait_rx16(output logic [15:0] d);
    int t;
    t = 0;
    while (b16.rx_valid !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("rx16_wait", {31'd0, b16.rx_valid}, 32'd1);
    d = b16.rx_data;
  endtask

  initial begin
    logic [7:0]  d8;
    logic [15:0] d16;
    int s_rise, s_rx, s_cs, s_mosi, bad, t;

    b8.tx_valid = 1'b0; b8.tx_data = '0; b8.tx_last = 1'b0; b8.cs_sel = '0;
    b8.cpol = 1'b0; b8.cpha = 1'b0; b8.clk_div = '0;
    b16.tx_valid = 1'b0; b16.tx_data = '0; b16.tx_last = 1'b0; b16.cs_sel = '0;
    b16.cpol = 1'b0; b16.cpha = 1'b0; b16.clk_div = '0;

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_tx_ready", {31'd0, b8.tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, b8.rx_valid}, 32'd0);
    check("rst_rx_data",  {24'd0, b8.rx_data},  32'd0);
    check("rst_busy",     {31'd0, b8.busy},     32'd0);
    check("rst_sclk",     {31'd0, sclk8},       32'd0);
    check("rst_mosi",     {31'd0, mosi8},       32'd0);
    check("rst_cs_n",     {28'd0, cs8},         32'hF);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx_ready", {31'd0, b8.tx_ready}, 32'd1);

    // Mode 0, div 1, loopback 0xA5 on CS0
    exp_cs8 = 4'hE;
    s_rise = rise8; s_rx = rxv8; s_cs = cs_bad8; s_mosi = mosi_bad8;
    send8(8'hA5, 1'b1, 2'd0, 1'b0, 1'b0, 8'd1);
    wait_rx8(d8);
    check("m0_rx_data", {24'd0, d8}, 32'hA5);
    check("m0_cs_at_rx", {28'd0, cs8}, 32'hE);
    @(negedge clk);
    check("m0_cs_in_hold", {28'd0, cs8}, 32'hE);
    @(negedge clk);
    check("m0_cs_released", {28'd0, cs8}, 32'hF);
    check("m0_busy_done", {31'd0, b8.busy}, 32'd0);
    check("m0_ready_done", {31'd0, b8.tx_ready}, 32'd1);
    check("m0_rise_count", rise8 - s_rise, 32'd8);
    bad = 0;
    for (int i = 1; i < 8; i++)
      if (rise_t8[(s_rise + i) & 255] - rise_t8[(s_rise + i - 1) & 255] != 40) bad++;
    check("m0_sclk_period", bad, 32'd0);
    check("m0_rx_strobes", rxv8 - s_rx, 32'd1);
    check("m0_cs_pattern", cs_bad8 - s_cs, 32'd0);
    check("m0_mosi_bits", {24'd0, cap8}, 32'hA5);
    check("m0_sclk_idle", {31'd0, sclk8}, 32'd0);

    // Mode 3, device answers 0xC3 while master sends 0x3C
    b8.cpol = 1'b1;
    @(negedge clk);
    check("m3_sclk_idle_before", {31'd0, sclk8}, 32'd1);
    dev_word = 8'hC3; miso_sel = 1'b1;
    s_rise = rise8; s_mosi = mosi_bad8;
    send8(8'h3C, 1'b1, 2'd0, 1'b1, 1'b1, 8'd1);
    wait_rx8(d8);
    check("m3_rx_data", {24'd0, d8}, 32'hC3);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("m3_sclk_idle_after", {31'd0, sclk8}, 32'd1);
    check("m3_busy_done", {31'd0, b8.busy}, 32'd0);
    check("m3_mosi_on_fall", mosi_bad8 - s_mosi, 32'd0);
    check("m3_mosi_bits", {24'd0, cap8}, 32'h3C);
    check("m3_rise_count", rise8 - s_rise, 32'd8);
    miso_sel = 1'b0;
    b8.cpol = 1'b0;
    @(negedge clk);

    // Burst of three words on CS2; later words offer different select/mode inputs
    exp_cs8 = 4'hB;
    s_rise = rise8; s_rx = rxv8; s_cs = cs_bad8;
    send8(8'h11, 1'b0, 2'd2, 1'b0, 1'b0, 8'd1);
    wait_rx8(d8);
    check("burst_rx0", {24'd0, d8}, 32'h11);
    send8(8'h22, 1'b0, 2'd0, 1'b1, 1'b1, 8'd1);
    wait_rx8(d8);
    check("burst_rx1", {24'd0, d8}, 32'h22);
    check("burst_cs_between", {28'd0, cs8}, 32'hB);
    send8(8'h33, 1'b1, 2'd3, 1'b0, 1'b0, 8'd1);
    wait_rx8(d8);
    check("burst_rx2", {24'd0, d8}, 32'h33);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("burst_cs_released", {28'd0, cs8}, 32'hF);
    check("burst_rx_strobes", rxv8 - s_rx, 32'd3);
    check("burst_cs_pattern", cs_bad8 - s_cs, 32'd0);
    check("burst_rise_count", rise8 - s_rise, 32'd24);

    // 16-bit build, clk_div=0, loopback 0xBEEF
    exp_cs16 = 5'h1E;
    s_rise = rise16; s_rx = rxv16; s_cs = cs_bad16;
    send16(16'hBEEF, 3'd0, 8'd0);
    wait_rx16(d16);
    check("w16_rx_data", {16'd0, d16}, 32'hBEEF);
    check("w16_rise_count", rise16 - s_rise, 32'd16);
    bad = 0;
    for (int i = 1; i < 16; i++)
      if (rise_t16[(s_rise + i) & 255] - rise_t16[(s_rise + i - 1) & 255] != 20) bad++;
    check("w16_sclk_period", bad, 32'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("w16_rx_strobes", rxv16 - s_rx, 32'd1);
    check("w16_cs_pattern", cs_bad16 - s_cs, 32'd0);

    // Out-of-range select on the 5-CS build: no line drops, word still completes
    exp_cs16 = 5'h1F;
    s_rise = rise16; s_cs = cs_bad16;
    send16(16'h1234, 3'd5, 8'd2);
    wait_rx16(d16);
    check("cs5_rx_data", {16'd0, d16}, 32'h1234);
    check("cs5_cs_at_rx", {27'd0, cs16}, 32'h1F);
    check("cs5_rise_count", rise16 - s_rise, 32'd16);
    check("cs5_cs_pattern", cs_bad16 - s_cs, 32'd0);

    // Reset right after SCLK edge 5 of a mode-0 transfer
    exp_cs8 = 4'hE;
    s_rise = rise8; s_rx = rxv8;
    send8(8'h5A, 1'b1, 2'd0, 1'b0, 1'b0, 8'd1);
    t = 0;
    while (rise8 - s_rise < 3 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) check("rst_edge_wait", rise8 - s_rise, 32'd3);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n",     {28'd0, cs8},         32'hF);
    check("midrst_sclk",     {31'd0, sclk8},       32'd0);
    check("midrst_busy",     {31'd0, b8.busy},     32'd0);
    check("midrst_rx_valid", {31'd0, b8.rx_valid}, 32'd0);
    check("midrst_rx_data",  {24'd0, b8.rx_data},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("midrst_no_strobe", rxv8 - s_rx, 32'd0);
    check("midrst_ready", {31'd0, b8.tx_ready}, 32'd1);

    // Recovery transfer after reset
    send8(8'h96, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
    wait_rx8(d8);
    check("recover_rx_data", {24'd0, d8}, 32'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
